// File: rtl/neuron_alu_arbiter.sv
// ---------------------------------------------------------------------------
// neuron_alu_arbiter
//
// Shares a single MUL/ACC/bias/activation ALU among NUM_REQ neuron control
// engines. A round-robin session arbiter locks the ALU to one neuron from the
// moment it is granted until its activation completes (or it drops its
// request), so the ALU's single accumulator is never interleaved between
// neurons. Every session is followed by one RELEASE cycle with no grant,
// which gives the ALU a drain cycle before the next owner starts.
//
// Optional feature (compile-time macro NEURON_ARB_TIMEOUT_EN):
//   an idle-session watchdog. While a session is OWNED, a counter clears on
//   any forwarded start or routed done and otherwise increments. Reaching
//   TIMEOUT_CYCLES forces RELEASE and sets the sticky TIMEOUT flag. Without
//   the macro there is no counter and TIMEOUT is tied low.
//
// Ports
//   CLK, RST         clock (rising edge), asynchronous active-high reset
//   REQ[N]           level request per neuron, held for the whole session
//   GNT[N]           registered one-hot grant
//   MUL_START[N]     per-neuron multiply start pulse
//   MUL_A/MUL_B      per-neuron operands, slice i = [i*WIDTH +: WIDTH]
//   ACC_MUX[N]       per-neuron accumulate select
//   BIAS_ADD_START[N] per-neuron bias-add/activation start pulse
//   ADD_DONE[N]      ALU add-done, routed to the owner only
//   ACT_DONE[N]      ALU activation-done, routed to the owner only
//   ALU_*            forwarded owner controls / done inputs from the ALU
//   BUSY             high whenever the arbiter is not IDLE
//   STRAY_ERR        sticky: a non-owner pulsed a start while a session ran
//   TIMEOUT          sticky watchdog flag (0 without NEURON_ARB_TIMEOUT_EN)
// ---------------------------------------------------------------------------
module neuron_alu_arbiter #(
    parameter int WIDTH          = 8,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         REQ,
    output logic [NUM_REQ-1:0]         GNT,
    input  logic [NUM_REQ-1:0]         MUL_START,
    input  logic [NUM_REQ*WIDTH-1:0]   MUL_A,
    input  logic [NUM_REQ*WIDTH-1:0]   MUL_B,
    input  logic [NUM_REQ-1:0]         ACC_MUX,
    input  logic [NUM_REQ-1:0]         BIAS_ADD_START,
    output logic [NUM_REQ-1:0]         ADD_DONE,
    output logic [NUM_REQ-1:0]         ACT_DONE,
    output logic                       ALU_MUL_START,
    output logic [WIDTH-1:0]           ALU_A,
    output logic [WIDTH-1:0]           ALU_B,
    output logic                       ALU_ACC_MUX,
    output logic                       ALU_BIAS_START,
    input  logic                       ALU_ADD_DONE,
    input  logic                       ALU_ACT_DONE,
    output logic                       BUSY,
    output logic                       STRAY_ERR,
    output logic                       TIMEOUT
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWNED   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               stray_err_q, stray_err_d;

    logic               owned;
    logic [NUM_REQ-1:0] owner_onehot;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               stray_seen;
    logic               timeout_hit;

    // (base + k) mod NUM_REQ without relying on NUM_REQ being a power of two
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= 32'(NUM_REQ)) begin
            s = s - 32'(NUM_REQ);
        end
        return s[IDX_W-1:0];
    endfunction

    // Per-neuron operand slices as arrays so the owner can be selected by index
    logic [WIDTH-1:0] mul_a_arr [NUM_REQ];
    logic [WIDTH-1:0] mul_b_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign mul_a_arr[gi] = MUL_A[gi*WIDTH +: WIDTH];
            assign mul_b_arr[gi] = MUL_B[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign owned        = (state_q == ST_OWNED);
    assign owner_onehot = owned ? (NUM_REQ'(1) << owner_q) : '0;

    // Forwarding is purely combinational and gated by OWNED, so everything on
    // the ALU side is zero in IDLE/RELEASE and during reset.
    always_comb begin
        ALU_MUL_START  = 1'b0;
        ALU_A          = '0;
        ALU_B          = '0;
        ALU_ACC_MUX    = 1'b0;
        ALU_BIAS_START = 1'b0;
        if (owned) begin
            ALU_MUL_START  = MUL_START[owner_q];
            ALU_A          = mul_a_arr[owner_q];
            ALU_B          = mul_b_arr[owner_q];
            ALU_ACC_MUX    = ACC_MUX[owner_q];
            ALU_BIAS_START = BIAS_ADD_START[owner_q];
        end
    end

    assign ADD_DONE = owner_onehot & {NUM_REQ{ALU_ADD_DONE}};
    assign ACT_DONE = owner_onehot & {NUM_REQ{ALU_ACT_DONE}};

    // Start pulses from anyone but the owner are dropped and flagged
    assign stray_seen = owned && (|((MUL_START | BIAS_ADD_START) & ~owner_onehot));

    // Round-robin pick: first requester at rr_ptr, rr_ptr+1, ... (wrapping)
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_valid && REQ[wrap_add(rr_ptr_q, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        stray_err_d = stray_err_q | stray_seen;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_valid) begin
                    state_d = ST_OWNED;
                    owner_d = pick_idx;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                end
            end
            ST_OWNED: begin
                // Activation done and request drop in the same cycle is just a
                // normal release; ACT_DONE still reaches the owner this cycle.
                if (ALU_ACT_DONE || !REQ[owner_q] || timeout_hit) begin
                    state_d  = ST_RELEASE;
                    gnt_d    = '0;
                    rr_ptr_d = wrap_add(owner_q, 1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            stray_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            stray_err_q <= stray_err_d;
        end
    end

`ifdef NEURON_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [TMR_W-1:0] tmr_inc;
    logic             timeout_q, timeout_d;
    logic             activity;

    // Any forwarded start or routed done counts as the session being alive
    assign activity = owned && (ALU_MUL_START || ALU_BIAS_START ||
                                ALU_ADD_DONE  || ALU_ACT_DONE);
    assign tmr_inc  = tmr_q + TMR_W'(1);

    always_comb begin
        tmr_d       = tmr_q;
        timeout_d   = timeout_q;
        timeout_hit = 1'b0;
        if (!owned || activity) begin
            tmr_d = '0;
        end else if (tmr_inc == TMR_W'(TIMEOUT_CYCLES)) begin
            timeout_hit = 1'b1;
            timeout_d   = 1'b1;
            tmr_d       = '0;
        end else begin
            tmr_d = tmr_inc;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
        end
    end

    assign TIMEOUT = timeout_q;
`else
    // Watchdog absent: sessions end only on activation done or request drop
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
    assign TIMEOUT            = 1'b0;
`endif

    assign GNT       = gnt_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign STRAY_ERR = stray_err_q;

endmodule

// File: tb/tb_neuron_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_neuron_alu_arbiter
//
// Directed-vector bench for neuron_alu_arbiter (WIDTH=8, NUM_REQ=4,
// TIMEOUT_CYCLES=8). Inputs change 1 time unit after the rising edge and
// outputs are sampled after a further settle delay, well away from the edge.
// ---------------------------------------------------------------------------
module tb_neuron_alu_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ;
    logic [N-1:0]   GNT;
    logic [N-1:0]   MUL_START;
    logic [N*W-1:0] MUL_A;
    logic [N*W-1:0] MUL_B;
    logic [N-1:0]   ACC_MUX;
    logic [N-1:0]   BIAS_ADD_START;
    logic [N-1:0]   ADD_DONE;
    logic [N-1:0]   ACT_DONE;
    logic           ALU_MUL_START;
    logic [W-1:0]   ALU_A;
    logic [W-1:0]   ALU_B;
    logic           ALU_ACC_MUX;
    logic           ALU_BIAS_START;
    logic           ALU_ADD_DONE;
    logic           ALU_ACT_DONE;
    logic           BUSY;
    logic           STRAY_ERR;
    logic           TIMEOUT;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    neuron_alu_arbiter #(
        .WIDTH          (W),
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .REQ            (REQ),
        .GNT            (GNT),
        .MUL_START      (MUL_START),
        .MUL_A          (MUL_A),
        .MUL_B          (MUL_B),
        .ACC_MUX        (ACC_MUX),
        .BIAS_ADD_START (BIAS_ADD_START),
        .ADD_DONE       (ADD_DONE),
        .ACT_DONE       (ACT_DONE),
        .ALU_MUL_START  (ALU_MUL_START),
        .ALU_A          (ALU_A),
        .ALU_B          (ALU_B),
        .ALU_ACC_MUX    (ALU_ACC_MUX),
        .ALU_BIAS_START (ALU_BIAS_START),
        .ALU_ADD_DONE   (ALU_ADD_DONE),
        .ALU_ACT_DONE   (ALU_ACT_DONE),
        .BUSY           (BUSY),
        .STRAY_ERR      (STRAY_ERR),
        .TIMEOUT        (TIMEOUT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        REQ            = '0;
        MUL_START      = '0;
        MUL_A          = '0;
        MUL_B          = '0;
        ACC_MUX        = '0;
        BIAS_ADD_START = '0;
        ALU_ADD_DONE   = 1'b0;
        ALU_ACT_DONE   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
    endtask

    // Bounded wait for any grant; the caller's compare catches an expiry
    task automatic wait_grant();
        for (int c = 0; c < 8 && GNT == '0; c++) begin
            tick();
        end
    endtask

    task automatic test_reset();
        logic [2*N+W*2+8:0] outs;
        clear_inputs();
        RST = 1'b1;
        #2;
        outs = {GNT, BUSY, STRAY_ERR, TIMEOUT, ALU_MUL_START, ALU_A, ALU_B,
                ALU_ACC_MUX, ALU_BIAS_START, ADD_DONE, ACT_DONE};
        total++;
        if (outs !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end else $display("reset_outputs ok");
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_single_req();
        do_reset();
        REQ = 4'b0010;
        #1;
        total++;
        if (GNT !== 4'b0000) begin
            bad++; $display("FAIL t1_no_early_grant: GNT=%b expected 0000", GNT);
        end
        tick();
        total++;
        if (GNT !== 4'b0010 || BUSY !== 1'b1) begin
            bad++; $display("FAIL t1_grant: GNT=%b BUSY=%b expected 0010/1", GNT, BUSY);
        end else $display("t1_grant ok");
        MUL_A[7:0]   = 8'hAA;
        MUL_A[15:8]  = 8'h12;
        MUL_B[15:8]  = 8'h34;
        MUL_START    = 4'b0010;
        #1;
        total++;
        if (ALU_A !== 8'h12 || ALU_B !== 8'h34 || ALU_MUL_START !== 1'b1) begin
            bad++;
            $display("FAIL t1_forward: A=%h B=%h start=%b expected 12/34/1",
                     ALU_A, ALU_B, ALU_MUL_START);
        end else $display("t1_forward ok");
        tick();
        MUL_START      = 4'b0000;
        ACC_MUX        = 4'b0010;
        BIAS_ADD_START = 4'b0010;
        ALU_ADD_DONE   = 1'b1;
        #1;
        total++;
        if (ADD_DONE !== 4'b0010 || ALU_ACC_MUX !== 1'b1 || ALU_BIAS_START !== 1'b1) begin
            bad++;
            $display("FAIL t1_add: ADD_DONE=%b acc=%b bias=%b expected 0010/1/1",
                     ADD_DONE, ALU_ACC_MUX, ALU_BIAS_START);
        end else $display("t1_add ok");
        tick();
        ALU_ADD_DONE   = 1'b0;
        BIAS_ADD_START = 4'b0000;
        ALU_ACT_DONE   = 1'b1;
        #1;
        total++;
        if (ACT_DONE !== 4'b0010) begin
            bad++; $display("FAIL t1_act_done: ACT_DONE=%b expected 0010", ACT_DONE);
        end else $display("t1_act_done ok");
        tick();
        ALU_ACT_DONE = 1'b0;
        REQ          = 4'b0110;
        #1;
        total++;
        if (GNT !== 4'b0000 || BUSY !== 1'b1 || ALU_A !== 8'h00) begin
            bad++;
            $display("FAIL t1_release: GNT=%b BUSY=%b A=%h expected 0000/1/00",
                     GNT, BUSY, ALU_A);
        end else $display("t1_release ok");
        tick();
        total++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0) begin
            bad++; $display("FAIL t1_idle: GNT=%b BUSY=%b expected 0000/0", GNT, BUSY);
        end
        tick();
        total++;
        if (GNT !== 4'b0100 || STRAY_ERR !== 1'b0) begin
            bad++;
            $display("FAIL t1_rr_ptr: GNT=%b stray=%b expected 0100/0", GNT, STRAY_ERR);
        end else $display("t1_rr_ptr ok");
    endtask

    task automatic test_fairness();
        int          order [5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] exp;
        do_reset();
        REQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant();
            exp = N'(1) << order[i];
            total++;
            if (GNT !== exp) begin
                bad++; $display("FAIL t2_order%0d: GNT=%b expected %b", i, GNT, exp);
            end else $display("t2_order%0d grant %b ok", i, GNT);
            ALU_ACT_DONE = 1'b1;
            tick();
            ALU_ACT_DONE = 1'b0;
        end
    endtask

    task automatic test_stray();
        do_reset();
        REQ = 4'b0001;
        tick();
        MUL_START = 4'b0100;
        #1;
        total++;
        if (ALU_MUL_START !== 1'b0) begin
            bad++; $display("FAIL t3_drop: ALU_MUL_START=%b expected 0", ALU_MUL_START);
        end
        tick();
        MUL_START = 4'b0000;
        REQ       = 4'b0000;
        #1;
        total++;
        if (STRAY_ERR !== 1'b1) begin
            bad++; $display("FAIL t3_stray_set: STRAY_ERR=%b expected 1", STRAY_ERR);
        end else $display("t3_stray_set ok");
        repeat (4) tick();
        total++;
        if (STRAY_ERR !== 1'b1) begin
            bad++; $display("FAIL t3_stray_sticky: STRAY_ERR=%b expected 1", STRAY_ERR);
        end
        do_reset();
        total++;
        if (STRAY_ERR !== 1'b0) begin
            bad++; $display("FAIL t3_stray_clear: STRAY_ERR=%b expected 0", STRAY_ERR);
        end else $display("t3_stray_clear ok");
    endtask

    task automatic test_abort();
        do_reset();
        REQ = 4'b1000;
        tick();
        total++;
        if (GNT !== 4'b1000) begin
            bad++; $display("FAIL t4_grant3: GNT=%b expected 1000", GNT);
        end
        REQ = 4'b0101;
        #1;
        total++;
        if (ACT_DONE !== 4'b0000) begin
            bad++; $display("FAIL t4_no_act: ACT_DONE=%b expected 0000", ACT_DONE);
        end
        tick();
        total++;
        if (GNT !== 4'b0000 || BUSY !== 1'b1) begin
            bad++; $display("FAIL t4_release: GNT=%b BUSY=%b expected 0000/1", GNT, BUSY);
        end
        tick();
        tick();
        total++;
        if (GNT !== 4'b0001) begin
            bad++; $display("FAIL t4_wrap: GNT=%b expected 0001", GNT);
        end else $display("t4_wrap ok");
    endtask

    task automatic test_simultaneous();
        do_reset();
        REQ = 4'b0100;
        tick();
        ALU_ACT_DONE = 1'b1;
        REQ          = 4'b0000;
        #1;
        total++;
        if (ACT_DONE !== 4'b0100) begin
            bad++; $display("FAIL t5_act_done: ACT_DONE=%b expected 0100", ACT_DONE);
        end else $display("t5_act_done ok");
        tick();
        ALU_ACT_DONE = 1'b0;
        total++;
        if (GNT !== 4'b0000 || BUSY !== 1'b1) begin
            bad++; $display("FAIL t5_release: GNT=%b BUSY=%b expected 0000/1", GNT, BUSY);
        end
        tick();
        total++;
        if (BUSY !== 1'b0 || GNT !== 4'b0000) begin
            bad++; $display("FAIL t5_single_release: GNT=%b BUSY=%b expected 0000/0", GNT, BUSY);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        REQ = 4'b0001;
        tick();
        MUL_START    = 4'b0001;
        MUL_A[7:0]   = 8'h5C;
        #1;
        total++;
        if (ALU_MUL_START !== 1'b1 || ALU_A !== 8'h5C) begin
            bad++;
            $display("FAIL mid_fwd: start=%b A=%h expected 1/5c", ALU_MUL_START, ALU_A);
        end
        RST = 1'b1;
        #1;
        total++;
        if (GNT !== 4'b0000 || ALU_MUL_START !== 1'b0 || ALU_A !== 8'h00 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: GNT=%b start=%b A=%h BUSY=%b expected 0000/0/00/0",
                     GNT, ALU_MUL_START, ALU_A, BUSY);
        end else $display("mid_reset ok");
        tick();
        RST = 1'b0;
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        REQ = 4'b0001;
        tick();
        repeat (7) tick();
        total++;
        if (GNT !== 4'b0001 || TIMEOUT !== 1'b0) begin
            bad++;
            $display("FAIL t6_before: GNT=%b TIMEOUT=%b expected 0001/0", GNT, TIMEOUT);
        end
        tick();
`ifdef NEURON_ARB_TIMEOUT_EN
        total++;
        if (GNT !== 4'b0000 || TIMEOUT !== 1'b1) begin
            bad++;
            $display("FAIL t6_timeout: GNT=%b TIMEOUT=%b expected 0000/1", GNT, TIMEOUT);
        end else $display("t6_timeout ok");
`else
        total++;
        if (GNT !== 4'b0001 || TIMEOUT !== 1'b0) begin
            bad++;
            $display("FAIL t6_no_watchdog: GNT=%b TIMEOUT=%b expected 0001/0", GNT, TIMEOUT);
        end else $display("t6_no_watchdog ok");
`endif
        REQ = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_fairness();
        test_stray();
        test_abort();
        test_simultaneous();
        test_mid_reset();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
